nibble_serial_subtractor: RTL and testbench

NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

---
 rtl/nibble_serial_subtractor.sv | 139 +++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_serial_subtractor: W-bit a - b computed one 4-bit digit per cycle |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module nibble_serial_subtractor #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   d,
  output logic                   borrow,
  output logic                   ovf,
  output logic                   zero
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            borrow_reg_q, borrow_reg_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    d_q, d_d;
  logic            borrow_q, borrow_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;

  logic [3:0]      dig_a;
  logic [3:0]      dig_b;
  logic [4:0]      dig_diff;

  // Current digit of each operand; bit 4 of the 5-bit difference is the borrow out.
  always_comb begin
    dig_a = 4'd0;
    dig_b = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDXW'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
    end
    dig_diff = {1'b0, dig_a} - {1'b0, dig_b} - {4'd0, borrow_reg_q};
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    borrow_reg_d = borrow_reg_q;
    a_d          = a_q;
    b_d          = b_q;
    d_d          = d_q;
    borrow_d     = borrow_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d          = a;
          b_d          = b;
          borrow_reg_d = 1'b0;
          idx_d        = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDXW'(i)) begin
            d_d[4*i +: 4] = dig_diff[3:0];
          end
        end
        borrow_reg_d = dig_diff[4];
        idx_d        = idx_q + 1'b1;
        // Flags are published only with the last digit so they stay coherent with d.
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          state_d  = DONE;
          borrow_d = dig_diff[4];
          ovf_d    = (a_q[W-1] != b_q[W-1]) && (d_d[W-1] != a_q[W-1]);
          zero_d   = (d_d == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      borrow_reg_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      d_q          <= '0;
      borrow_q     <= 1'b0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      borrow_reg_q <= borrow_reg_d;
      a_q          <= a_d;
      b_q          <= b_d;
      d_q          <= d_d;
      borrow_q     <= borrow_d;
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nibble_serial_subtractor: vectors, corner sequences, random traffic   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_nibble_serial_subtractor;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int NOPS    = 4000;
  localparam int NVEC    = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         borrow;
    logic         ovf;
    logic         zero;
  } vec_t;

  logic         clk;
  logic         nrst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         borrow;
  logic         ovf;
  logic         zero;

  int checks   = 0;
  int failures = 0;

  vec_t         vecs [NVEC];
  logic [W+2:0] expq [$];
  int           consumed;

  nibble_serial_subtractor #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .borrow    (borrow),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: plain integer arithmetic on the whole operands.
  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] dd;
    int           sx;
    int           sy;
    int           sd;
    logic         bo;
    logic         ov;
    dd = W'(x - y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    sd = sx - sy;
    bo = (x < y);
    ov = (sd > (2**(W-1)) - 1) || (sd < -(2**(W-1)));
    return {dd, bo, ov, (dd == '0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb);
    @(negedge clk);
    chk("start_in_ready", {31'd0, in_ready}, 32'd1);
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    chk("accepted_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 4 * NIBBLES + 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consume_out_valid", {31'd0, out_valid}, 32'd0);
    chk("consume_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    start_op(v.a, v.b);
    wait_out(lat);
    chk("latency", lat, NIBBLES);
    chk("vec_d", {16'd0, d}, {16'd0, v.d});
    chk("vec_borrow", {31'd0, borrow}, {31'd0, v.borrow});
    chk("vec_ovf", {31'd0, ovf}, {31'd0, v.ovf});
    chk("vec_zero", {31'd0, zero}, {31'd0, v.zero});
    consume();
    chk("retain_d", {16'd0, d}, {16'd0, v.d});
    chk("retain_flags", {29'd0, borrow, ovf, zero}, {29'd0, v.borrow, v.ovf, v.zero});
  endtask

  initial begin
    int           lat;
    logic [W-1:0] hold_d;
    logic [2:0]   hold_f;

    vecs[0] = '{a: 16'h1234, b: 16'h0234, d: 16'h1000, borrow: 1'b0, ovf: 1'b0, zero: 1'b0};
    vecs[1] = '{a: 16'h0000, b: 16'h0001, d: 16'hFFFF, borrow: 1'b1, ovf: 1'b0, zero: 1'b0};
    vecs[2] = '{a: 16'h8000, b: 16'h0001, d: 16'h7FFF, borrow: 1'b0, ovf: 1'b1, zero: 1'b0};
    vecs[3] = '{a: 16'hABCD, b: 16'hABCD, d: 16'h0000, borrow: 1'b0, ovf: 1'b0, zero: 1'b1};
    vecs[4] = '{a: 16'h7FFF, b: 16'hFFFF, d: 16'h8000, borrow: 1'b1, ovf: 1'b1, zero: 1'b0};
    vecs[5] = '{a: 16'h1000, b: 16'h0001, d: 16'h0FFF, borrow: 1'b0, ovf: 1'b0, zero: 1'b0};
    vecs[6] = '{a: 16'hFFFF, b: 16'h0000, d: 16'hFFFF, borrow: 1'b0, ovf: 1'b0, zero: 1'b0};
    vecs[7] = '{a: 16'h8000, b: 16'h7FFF, d: 16'h0001, borrow: 1'b0, ovf: 1'b1, zero: 1'b0};

    nrst      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_d", {16'd0, d}, 32'd0);
    chk("rst_flags", {29'd0, borrow, ovf, zero}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i]);
    end

    // Backpressure: result held while new operands are offered and ignored.
    start_op(16'h1234, 16'h0234);
    wait_out(lat);
    chk("bp_latency", lat, NIBBLES);
    hold_d = d;
    hold_f = {borrow, ovf, zero};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("bp_d_stable", {16'd0, d}, {16'd0, hold_d});
      chk("bp_flags_stable", {29'd0, borrow, ovf, zero}, {29'd0, hold_f});
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    chk("bp_d_value", {16'd0, hold_d}, 32'h1000);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 16'h0010;
    b         = 16'h0001;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_accepted", {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    chk("bp_next_latency", lat, NIBBLES);
    chk("bp_next_d", {16'd0, d}, 32'h000F);
    consume();

    // Reset in the middle of RUN after two digits.
    start_op(16'hFFFF, 16'h1111);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_not_done", {31'd0, out_valid}, 32'd0);
    #2;
    nrst = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_d", {16'd0, d}, 32'd0);
    chk("mid_rst_flags", {29'd0, borrow, ovf, zero}, 32'd0);
    in_valid = 1'b1;
    a        = 16'h0005;
    b        = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("mid_hold_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_hold_in_ready", {31'd0, in_ready}, 32'd1);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post_rst_accept", {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    chk("post_rst_latency", lat, NIBBLES);
    chk("post_rst_d", {16'd0, d}, 32'h0002);
    chk("post_rst_flags", {29'd0, borrow, ovf, zero}, 32'd0);
    consume();

    // Random traffic against the scoreboard.
    consumed = 0;
    fork
      begin
        for (int n = 0; n < NOPS; n++) begin
          logic [W-1:0] ra;
          logic [W-1:0] rb;
          bit           done;
          ra = W'($urandom);
          rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          @(negedge clk);
          a        = ra;
          b        = rb;
          in_valid = 1'b1;
          done     = 1'b0;
          for (int w = 0; w < 40 && !done; w++) begin
            if (in_ready) begin
              expq.push_back(model(ra, rb));
              done = 1'b1;
            end
            @(negedge clk);
          end
          if (!done) begin
            chk("rand_accept_timeout", 32'd0, 32'd1);
          end
          in_valid = 1'b0;
          a        = W'($urandom);
          b        = W'($urandom);
        end
      end
      begin
        for (int c = 0; c < NOPS * 20 && consumed < NOPS; c++) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
              chk("rand_duplicate", 32'd1, 32'd0);
            end else begin
              chk("rand_result", {13'd0, d, borrow, ovf, zero}, {13'd0, expq.pop_front()});
            end
            consumed++;
          end
        end
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    chk("rand_count", consumed, NOPS);
    chk("rand_queue_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
